// File: rtl/cnn_layer_pkg.sv
// ---------------------------------------------------------------------------
// cnn_layer_pkg
// Shared definitions for the convolution layer engine:
//   - default activation / accumulator / batch-norm coefficient widths
//   - the layer controller state encoding
//   - the ReLU6 upper clamp value
//   - address-index helpers for the flat input, weight, batch-norm and
//     output memories, plus a width helper for counters and addresses
// ---------------------------------------------------------------------------
package cnn_layer_pkg;

    localparam int ACT_BITS  = 4;
    localparam int ACC_BITS  = 32;
    localparam int BN_BITS   = 16;
    localparam int RELU6_MAX = 6;

    typedef logic signed [ACT_BITS-1:0] act_t;
    typedef logic signed [ACC_BITS-1:0] acc_t;
    typedef logic signed [BN_BITS-1:0]  bn_coef_t;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        BN,
        CLAMP_WR,
        DONE
    } state_t;

    // Width needed to index 'depth' entries; never below one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Input feature map: channel-major, then row, then column.
    function automatic int ifmap_idx(input int c, input int r, input int x,
                                     input int h, input int w);
        return c * h * w + r * w + x;
    endfunction

    // Weights: [oc][ic][ky][kx] flattened.
    function automatic int weight_idx(input int oc, input int ic, input int ky,
                                      input int kx, input int in_c, input int k);
        return ((oc * in_c + ic) * k + ky) * k + kx;
    endfunction

    // Batch-norm table: sel=0 scale, sel=1 bias.
    function automatic int bn_idx(input int oc, input int sel);
        return oc * 2 + sel;
    endfunction

    // Output buffer: output-channel-major, then row, then column.
    function automatic int ofmap_idx(input int oc, input int r, input int x,
                                     input int h, input int w);
        return oc * h * w + r * w + x;
    endfunction

endpackage

// File: rtl/relu6_bn_quant.sv
// ---------------------------------------------------------------------------
// relu6_bn_quant
// Combinational batch-norm + ReLU6 quantiser for one accumulated output:
//   y = ((acc * scale) >>> BN_SHIFT) + bias, clamped to 0..RELU6_MAX.
// All intermediates are wide enough that nothing wraps before the clamp.
//
// Build option: define CONV2D_BN_ROUND_EN to add half an LSB before the
// arithmetic shift (round half up); otherwise the shift truncates (floor).
//
// Ports:
//   acc   in  ACC_W  signed accumulator
//   scale in  BN_W   signed batch-norm scale (fixed point, BN_SHIFT frac bits)
//   bias  in  BN_W   signed batch-norm bias (integer)
//   q     out DW     clamped result, 0..RELU6_MAX
// ---------------------------------------------------------------------------
module relu6_bn_quant
    import cnn_layer_pkg::*;
#(
    parameter int ACC_W    = ACC_BITS,
    parameter int BN_W     = BN_BITS,
    parameter int BN_SHIFT = 12,
    parameter int DW       = ACT_BITS
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [BN_W-1:0]  scale,
    input  logic signed [BN_W-1:0]  bias,
    output logic signed [DW-1:0]    q
);

    localparam int PW = ACC_W + BN_W;   // full product width
    localparam int YW = PW + 1;         // room for the bias add

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_adj;
    logic signed [PW-1:0] shifted;
    logic signed [YW-1:0] y;

    assign prod = PW'(acc) * PW'(scale);

`ifdef CONV2D_BN_ROUND_EN
    localparam logic signed [PW-1:0] HALF_LSB = PW'(1) <<< (BN_SHIFT - 1);
    assign prod_adj = prod + HALF_LSB;
`else
    assign prod_adj = prod;
`endif

    assign shifted = prod_adj >>> BN_SHIFT;
    assign y       = YW'(shifted) + YW'(bias);

    always_comb begin
        q = '0;
        if (y[YW-1]) begin
            q = '0;                         // negative -> 0
        end else if (y > YW'(RELU6_MAX)) begin
            q = DW'(RELU6_MAX);
        end else begin
            q = y[DW-1:0];
        end
    end

endmodule

// File: rtl/conv2d_16x16x32_bn_relu6_64ch.sv
// ---------------------------------------------------------------------------
// conv2d_16x16x32_bn_relu6_64ch
// 3x3 / stride 1 / zero-pad 1 convolution over an IN_H x IN_W x IN_C signed
// feature map producing OUT_C channels. Each output is accumulated one
// multiply per cycle (IN_C*K*K cycles), passed through per-channel batch
// norm and ReLU6 (one cycle, registered), then written to the internal output
// buffer (one cycle). A full layer therefore takes
// OUT_C*IN_H*IN_W*(IN_C*K*K + 2) cycles from the start-sampling edge to done.
//
// Build option: CONV2D_BN_ROUND_EN selects round-half-up in the batch-norm
// shift (see relu6_bn_quant); default is truncation.
//
// Ports:
//   clk        in   1   clock, rising edge
//   resetn     in   1   asynchronous active-low reset
//   start      in   1   one-cycle pulse; honoured only in IDLE or DONE
//   read_addr  in  32   output buffer address (oc*H*W + r*W + x)
//   read_data  out DW   registered output-buffer word, 0 when out of range
//   done       out  1   output buffer complete; held until the next start
// ---------------------------------------------------------------------------
module conv2d_16x16x32_bn_relu6_64ch
    import cnn_layer_pkg::*;
#(
    parameter int    IN_H        = 16,
    parameter int    IN_W        = 16,
    parameter int    IN_C        = 32,
    parameter int    OUT_C       = 64,
    parameter int    K           = 3,
    parameter int    DW          = ACT_BITS,
    parameter int    ACC_W       = ACC_BITS,
    parameter int    BN_W        = BN_BITS,
    parameter int    BN_SHIFT    = 12,
    parameter string IFMAP_FILE  = "ifmap.mem",
    parameter string WEIGHT_FILE = "weights.mem",
    parameter string BN_FILE     = "bn.mem"
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [31:0]          read_addr,
    output logic signed [DW-1:0] read_data,
    output logic                 done
);

    localparam int PAD       = K / 2;
    localparam int IF_DEPTH  = IN_C * IN_H * IN_W;
    localparam int W_DEPTH   = OUT_C * IN_C * K * K;
    localparam int BN_DEPTH  = 2 * OUT_C;
    localparam int OUT_DEPTH = OUT_C * IN_H * IN_W;

    localparam int IF_AW = addr_w(IF_DEPTH);
    localparam int W_AW  = addr_w(W_DEPTH);
    localparam int BN_AW = addr_w(BN_DEPTH);
    localparam int OB_AW = addr_w(OUT_DEPTH);

    localparam int X_W  = addr_w(IN_W);
    localparam int R_W  = addr_w(IN_H);
    localparam int IC_W = addr_w(IN_C);
    localparam int OC_W = addr_w(OUT_C);
    localparam int K_W  = addr_w(K);

    localparam logic [X_W-1:0]  X_LAST  = X_W'(IN_W - 1);
    localparam logic [R_W-1:0]  R_LAST  = R_W'(IN_H - 1);
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(IN_C - 1);
    localparam logic [OC_W-1:0] OC_LAST = OC_W'(OUT_C - 1);
    localparam logic [K_W-1:0]  K_LAST  = K_W'(K - 1);

    // ---------------------------------------------------------------- memories
    logic signed [DW-1:0]   ifmap_mem  [IF_DEPTH];
    logic signed [DW-1:0]   weight_mem [W_DEPTH];
    logic signed [BN_W-1:0] bn_mem     [BN_DEPTH];
    logic signed [DW-1:0]   out_buf    [OUT_DEPTH];

    // ---------------------------------------------------------------- state
    state_t state_reg;
    state_t state_next;

    logic [X_W-1:0]  x_reg;
    logic [R_W-1:0]  r_reg;
    logic [OC_W-1:0] oc_reg;
    logic [IC_W-1:0] ic_reg;
    logic [K_W-1:0]  ky_reg;
    logic [K_W-1:0]  kx_reg;

    logic signed [ACC_W-1:0] acc_reg;
    logic signed [DW-1:0]    q_reg;
    logic                    done_reg;

    logic last_tap;
    logic last_out;

    assign last_tap = (ic_reg == IC_LAST) && (ky_reg == K_LAST) && (kx_reg == K_LAST);
    assign last_out = (x_reg == X_LAST) && (r_reg == R_LAST) && (oc_reg == OC_LAST);
    assign done     = done_reg;

    // ---------------------------------------------------------------- tap fetch
    int                    iy;
    int                    ix;
    logic                  tap_valid;
    logic [IF_AW-1:0]      if_addr;
    logic [W_AW-1:0]       w_addr;
    logic signed [DW-1:0]  act;
    logic signed [DW-1:0]  wgt;
    logic signed [2*DW-1:0] tap_prod;

    always_comb begin
        iy        = int'(r_reg) + int'(ky_reg) - PAD;
        ix        = int'(x_reg) + int'(kx_reg) - PAD;
        tap_valid = (iy >= 0) && (iy < IN_H) && (ix >= 0) && (ix < IN_W);
        // Padding taps never touch the memory; keep the address in range.
        if_addr   = '0;
        if (tap_valid) begin
            if_addr = IF_AW'(ifmap_idx(int'(ic_reg), iy, ix, IN_H, IN_W));
        end
        w_addr    = W_AW'(weight_idx(int'(oc_reg), int'(ic_reg), int'(ky_reg),
                                     int'(kx_reg), IN_C, K));
        act       = tap_valid ? ifmap_mem[if_addr] : '0;
        wgt       = weight_mem[w_addr];
        tap_prod  = act * wgt;
    end

    // ---------------------------------------------------------------- batch norm
    logic signed [BN_W-1:0] bn_scale;
    logic signed [BN_W-1:0] bn_bias;
    logic signed [DW-1:0]   bn_q;
    logic [OB_AW-1:0]       wr_addr;

    assign bn_scale = bn_mem[BN_AW'(bn_idx(int'(oc_reg), 0))];
    assign bn_bias  = bn_mem[BN_AW'(bn_idx(int'(oc_reg), 1))];
    assign wr_addr  = OB_AW'(ofmap_idx(int'(oc_reg), int'(r_reg), int'(x_reg), IN_H, IN_W));

    relu6_bn_quant #(
        .ACC_W    (ACC_W),
        .BN_W     (BN_W),
        .BN_SHIFT (BN_SHIFT),
        .DW       (DW)
    ) u_bn_quant (
        .acc   (acc_reg),
        .scale (bn_scale),
        .bias  (bn_bias),
        .q     (bn_q)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = MAC;
            MAC:        if (last_tap) state_next = BN;
            BN:         state_next = CLAMP_WR;
            CLAMP_WR:   state_next = last_out ? DONE : MAC;
            default:    state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_reg    <= '0;
            r_reg    <= '0;
            oc_reg   <= '0;
            ic_reg   <= '0;
            ky_reg   <= '0;
            kx_reg   <= '0;
            acc_reg  <= '0;
            q_reg    <= '0;
            done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        done_reg <= 1'b0;
                        acc_reg  <= '0;
                        x_reg    <= '0;
                        r_reg    <= '0;
                        oc_reg   <= '0;
                        ic_reg   <= '0;
                        ky_reg   <= '0;
                        kx_reg   <= '0;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + ACC_W'(tap_prod);
                    // kx fastest, then ky, then ic; all wrap to 0 after the
                    // last tap so the next output starts clean.
                    if (kx_reg == K_LAST) begin
                        kx_reg <= '0;
                        if (ky_reg == K_LAST) begin
                            ky_reg <= '0;
                            ic_reg <= (ic_reg == IC_LAST) ? '0 : ic_reg + 1'b1;
                        end else begin
                            ky_reg <= ky_reg + 1'b1;
                        end
                    end else begin
                        kx_reg <= kx_reg + 1'b1;
                    end
                end
                BN: begin
                    q_reg <= bn_q;
                end
                CLAMP_WR: begin
                    acc_reg <= '0;
                    if (x_reg == X_LAST) begin
                        x_reg <= '0;
                        if (r_reg == R_LAST) begin
                            r_reg  <= '0;
                            oc_reg <= (oc_reg == OC_LAST) ? '0 : oc_reg + 1'b1;
                        end else begin
                            r_reg <= r_reg + 1'b1;
                        end
                    end else begin
                        x_reg <= x_reg + 1'b1;
                    end
                    if (last_out) begin
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- output buffer
    // Write port carries no reset so the array maps onto block RAM; the
    // buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (state_reg == CLAMP_WR) begin
            out_buf[wr_addr] <= q_reg;
        end
    end

    // Registered read, always active; same-cycle write to the same address
    // returns the previous contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            read_data <= '0;
        end else if (read_addr < 32'(OUT_DEPTH)) begin
            read_data <= out_buf[read_addr[OB_AW-1:0]];
        end else begin
            read_data <= '0;
        end
    end

endmodule

// File: tb/tb_conv2d_16x16x32_bn_relu6_64ch.sv
// ---------------------------------------------------------------------------
// tb_conv2d_16x16x32_bn_relu6_64ch
// Runs the convolution engine at a reduced geometry (4x5x2 in, 8 out
// channels) so whole layers fit in a short simulation. Memories are loaded
// directly into the DUT arrays; expected outputs come from a direct
// convolution model over multi-dimensional arrays.
// ---------------------------------------------------------------------------
module tb_conv2d_16x16x32_bn_relu6_64ch;

    localparam int H     = 4;
    localparam int W     = 5;
    localparam int IC    = 2;
    localparam int OC    = 8;
    localparam int KK    = 3;
    localparam int DWB   = 4;
    localparam int BNW   = 16;
    localparam int SH    = 12;
    localparam int PLANE = H * W;
    localparam int NOUT  = OC * PLANE;
    localparam int LAT   = NOUT * (IC * KK * KK + 2);
    localparam int BUDGET = LAT + 200;

`ifdef CONV2D_BN_ROUND_EN
    localparam int ROUND_EXP = 2;
`else
    localparam int ROUND_EXP = 1;
`endif

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   start;
    logic [31:0]            read_addr;
    logic signed [DWB-1:0]  read_data;
    logic                   done;

    always #5 clk = ~clk;

    conv2d_16x16x32_bn_relu6_64ch #(
        .IN_H        (H),
        .IN_W        (W),
        .IN_C        (IC),
        .OUT_C       (OC),
        .K           (KK),
        .DW          (DWB),
        .ACC_W       (32),
        .BN_W        (BNW),
        .BN_SHIFT    (SH),
        .IFMAP_FILE  (""),
        .WEIGHT_FILE (""),
        .BN_FILE     ("")
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .read_addr (read_addr),
        .read_data (read_data),
        .done      (done)
    );

    // ---------------------------------------------------------------- model
    int in_m [IC][H][W];
    int w_m  [OC][IC][KK][KK];
    int sc_m [OC];
    int bi_m [OC];
    int exp_q [NOUT];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    task automatic compute_model();
        longint acc;
        longint p;
        longint y;
        int     iy;
        int     ix;
        for (int oc = 0; oc < OC; oc++)
            for (int r = 0; r < H; r++)
                for (int x = 0; x < W; x++) begin
                    acc = 0;
                    for (int ic = 0; ic < IC; ic++)
                        for (int ky = 0; ky < KK; ky++)
                            for (int kx = 0; kx < KK; kx++) begin
                                iy = r + ky - KK / 2;
                                ix = x + kx - KK / 2;
                                if (iy >= 0 && iy < H && ix >= 0 && ix < W)
                                    acc += longint'(in_m[ic][iy][ix] * w_m[oc][ic][ky][kx]);
                            end
                    p = acc * longint'(sc_m[oc]);
`ifdef CONV2D_BN_ROUND_EN
                    p = p + (longint'(1) <<< (SH - 1));
`endif
                    y = (p >>> SH) + longint'(bi_m[oc]);
                    exp_q[oc * PLANE + r * W + x] = (y < 0) ? 0 : ((y > 6) ? 6 : int'(y));
                end
    endtask

    // mode: 0 all ones, 1 negative weights, 2 bias only, 3 centre tap,
    //       4 rounding probe, other values random
    task automatic setup(input int mode);
        bit ctr;
        for (int ic = 0; ic < IC; ic++)
            for (int r = 0; r < H; r++)
                for (int x = 0; x < W; x++) begin
                    case (mode)
                        0, 1, 2, 4: in_m[ic][r][x] = 1;
                        3:          in_m[ic][r][x] = (ic == 0) ? (x % 7) : 5;
                        default:    in_m[ic][r][x] = int'($urandom_range(15)) - 8;
                    endcase
                    dut.ifmap_mem[ic * PLANE + r * W + x] = DWB'(in_m[ic][r][x]);
                end
        for (int oc = 0; oc < OC; oc++) begin
            for (int ic = 0; ic < IC; ic++)
                for (int ky = 0; ky < KK; ky++)
                    for (int kx = 0; kx < KK; kx++) begin
                        ctr = (ic == 0) && (ky == 1) && (kx == 1);
                        case (mode)
                            0:       w_m[oc][ic][ky][kx] = 1;
                            1:       w_m[oc][ic][ky][kx] = -1;
                            2:       w_m[oc][ic][ky][kx] = 0;
                            3:       w_m[oc][ic][ky][kx] = ctr ? 1 : 0;
                            4:       w_m[oc][ic][ky][kx] = ctr ? 3 : 0;
                            default: w_m[oc][ic][ky][kx] = int'($urandom_range(15)) - 8;
                        endcase
                        dut.weight_mem[((oc * IC + ic) * KK + ky) * KK + kx] =
                            DWB'(w_m[oc][ic][ky][kx]);
                    end
            case (mode)
                0, 1, 3: begin sc_m[oc] = 4096; bi_m[oc] = 0; end
                2:       begin sc_m[oc] = 0;    bi_m[oc] = oc % 7; end
                4:       begin sc_m[oc] = 2048; bi_m[oc] = 0; end
                default: begin
                    sc_m[oc] = int'($urandom_range(1200)) - 400;
                    bi_m[oc] = int'($urandom_range(8)) - 4;
                end
            endcase
            dut.bn_mem[oc * 2]     = BNW'(sc_m[oc]);
            dut.bn_mem[oc * 2 + 1] = BNW'(bi_m[oc]);
        end
        compute_model();
    endtask

    task automatic read_word(input int addr, output int val);
        @(negedge clk);
        read_addr = addr;
        @(posedge clk);
        #1;
        val = int'(read_data);
    endtask

    // Start a layer and count cycles to done; optionally pulse start while
    // busy, which must not disturb anything.
    task automatic run_layer(input bit poke_start);
        int cycles;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 0;
        check("done_cleared_on_start", int'(done), 0);
        while (!done && cycles < BUDGET) begin
            @(posedge clk);
            #1;
            cycles++;
            start = poke_start && (cycles == 37);
        end
        start = 1'b0;
        check("latency", cycles, LAT);
    endtask

    task automatic sweep(input string tag);
        int v;
        for (int a = 0; a < NOUT; a++) begin
            read_word(a, v);
            n_checks++;
            if (v != exp_q[a]) begin
                n_fail++;
                $display("FAIL %s addr %0d: got %0d, expected %0d", tag, a, v, exp_q[a]);
            end
        end
        $display("sweep %s: %0d addresses compared", tag, NOUT);
        check({tag, "_done_held"}, int'(done), 1);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        int    mode;
        int    addr;
        int    expect_v;
        string name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(input int mode, input int addr, input int e, input string n);
        vec_t v;
        v.mode = mode; v.addr = addr; v.expect_v = e; v.name = n;
        tbl.push_back(v);
    endfunction

    initial begin
        int v;
        int cur_mode;

        resetn    = 1'b0;
        start     = 1'b0;
        read_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", int'(done), 0);
        check("reset_read_data", int'(read_data), 0);
        @(negedge clk);
        resetn = 1'b1;

        add_vec(0, 0,         6, "ones_corner");
        add_vec(0, W + 1,     6, "ones_interior");
        add_vec(0, NOUT - 1,  6, "ones_last");
        add_vec(1, 0,         0, "neg_corner");
        add_vec(1, 27,        0, "neg_interior");
        add_vec(2, 0,         0, "bias_oc0");
        add_vec(2, PLANE,     1, "bias_oc1");
        add_vec(2, 6 * PLANE, 6, "bias_oc6");
        add_vec(2, NOUT - 1,  0, "bias_last");
        add_vec(3, 0,         0, "centre_x0");
        add_vec(3, W - 1,     4, "centre_corner_x4");
        add_vec(3, PLANE + W + 3, 3, "centre_oc1_r1_x3");
        add_vec(3, NOUT - 1,  4, "centre_last");
        add_vec(4, 0,         ROUND_EXP, "round_corner");
        add_vec(4, 77,        ROUND_EXP, "round_mid");

        cur_mode = -1;
        foreach (tbl[i]) begin
            if (tbl[i].mode != cur_mode) begin
                cur_mode = tbl[i].mode;
                setup(cur_mode);
                run_layer(1'b0);
                sweep($sformatf("mode%0d", cur_mode));
            end
            read_word(tbl[i].addr, v);
            check(tbl[i].name, v, tbl[i].expect_v);
        end

        // Random data, with a stray start pulse mid-run.
        setup(5);
        run_layer(1'b1);
        sweep("random");
        // Second start after done must reproduce the same buffer.
        run_layer(1'b0);
        sweep("random_rerun");

        // Abort mid-run with new data, then recompute from scratch.
        setup(6);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", int'(done), 0);
        check("abort_read_data", int'(read_data), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_stays_idle", int'(done), 0);
        run_layer(1'b0);
        sweep("after_abort");

        // Out-of-range reads.
        read_word(NOUT, v);
        check("oob_first", v, 0);
        read_word(16384, v);
        check("oob_16384", v, 0);
        read_word(-1, v);
        check("oob_max", v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
